// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: flit type codes, head-flit field layout and
// the packetizer FSM state type.
package noc_pkg;

  localparam logic [1:0] FLIT_TYPE_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TYPE_TAIL = 2'b10;

  localparam int unsigned TYPE_LSB = 14;
  localparam int unsigned TYPE_W   = 2;
  localparam int unsigned DEST_LSB = 10;
  localparam int unsigned DEST_W   = 4;
  localparam int unsigned SRC_LSB  = 6;
  localparam int unsigned SRC_W    = 4;
  localparam int unsigned SEQ_LSB  = 0;
  localparam int unsigned SEQ_W    = 6;
  localparam int unsigned BASE_FLIT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    TAIL
  } pkt_state_t;

  function automatic logic [BASE_FLIT_W-1:0] make_head(
    input logic [DEST_W-1:0] dest,
    input logic [SRC_W-1:0]  src,
    input logic [SEQ_W-1:0]  seq
  );
    logic [BASE_FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: TYPE_W] = FLIT_TYPE_HEAD;
    f[DEST_LSB +: DEST_W] = dest;
    f[SRC_LSB  +: SRC_W]  = src;
    f[SEQ_LSB  +: SEQ_W]  = seq;
    return f;
  endfunction

endpackage

// File: rtl/packetizer_fifo.sv
// DATA_W x DEPTH synchronous FIFO with async active-high reset; also flags
// when exactly one word is held so the packetizer can chain packets.
module packetizer_fifo #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              single
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_fire, rd_fire;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign single  = (count_q == CW'(1));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = wr_en && !full;
    rd_fire  = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
    mem_d    = mem_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/core_packetizer.sv
// Wraps buffered core result words into head+tail NoC packets for the router.
// Optional PKT_SEQ_EN macro enables the 6-bit per-packet sequence counter.
module core_packetizer
  import noc_pkg::*;
#(
  parameter int unsigned      DATA_W = 11,
  parameter int unsigned      FLIT_W = 16,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [SRC_W-1:0] SRC_ID = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] dest_addr,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              flit_tail
);

  pkt_state_t        state_q, state_d;
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic              flit_valid_q, flit_valid_d;
  logic              flit_tail_q, flit_tail_d;
  logic [FLIT_W-1:0] head_word, tail_word;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, fifo_single;
  logic              wr_en, tail_fire;
  logic [SEQ_W-1:0]  seq_d;

  assign in_ready   = !RESET && !fifo_full;
  assign wr_en      = in_valid && in_ready;
  assign tail_fire  = (state_q == TAIL) && flit_ready;
  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign flit_tail  = flit_tail_q;

  packetizer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (tail_fire),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .single  (fifo_single)
  );

`ifdef PKT_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  always_comb begin
    seq_d = seq_q;
    if (tail_fire) begin
      seq_d = seq_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end
`else
  assign seq_d = '0;
`endif

  // Head flits carry the post-increment sequence so a chained head sees the new value.
  always_comb begin
    head_word = '0;
    head_word[BASE_FLIT_W-1:0] = make_head(dest_addr, SRC_ID, seq_d);
    tail_word = '0;
    tail_word[TYPE_LSB +: TYPE_W] = FLIT_TYPE_TAIL;
    tail_word[DATA_W-1:0] = fifo_rd_data;
  end

  always_comb begin
    state_d      = state_q;
    flit_out_d   = flit_out_q;
    flit_valid_d = flit_valid_q;
    flit_tail_d  = flit_tail_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d      = HEAD;
          flit_out_d   = head_word;
          flit_valid_d = 1'b1;
          flit_tail_d  = 1'b0;
        end
      end
      HEAD: begin
        if (flit_ready) begin
          state_d     = TAIL;
          flit_out_d  = tail_word;
          flit_tail_d = 1'b1;
        end
      end
      TAIL: begin
        if (flit_ready) begin
          // A word written on the popping edge keeps the FIFO non-empty.
          if (!fifo_single || wr_en) begin
            state_d      = HEAD;
            flit_out_d   = head_word;
            flit_valid_d = 1'b1;
            flit_tail_d  = 1'b0;
          end else begin
            state_d      = IDLE;
            flit_out_d   = '0;
            flit_valid_d = 1'b0;
            flit_tail_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        flit_out_d   = '0;
        flit_valid_d = 1'b0;
        flit_tail_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_tail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      flit_tail_q  <= flit_tail_d;
    end
  end

endmodule

// File: tb/tb_core_packetizer.sv
// Directed and scoreboarded bench for core_packetizer (SRC_ID=2, DEPTH=4).
module tb_core_packetizer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dest_addr;
  logic [15:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        flit_tail;

  int          checks = 0;
  int          failures = 0;
  logic [5:0]  exp_seq = '0;
  logic [10:0] words [4];

  always #5 CLK = ~CLK;

  core_packetizer #(
    .DATA_W (11),
    .FLIT_W (16),
    .DEPTH  (4),
    .SRC_ID (4'd2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dest_addr  (dest_addr),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_tail  (flit_tail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [15:0] head_exp(input logic [3:0] d);
`ifdef PKT_SEQ_EN
    return {2'b01, d, 4'd2, exp_seq};
`else
    return {2'b01, d, 4'd2, 6'd0};
`endif
  endfunction

  function automatic logic [15:0] tail_exp(input logic [10:0] w);
    return {2'b10, 3'b000, w};
  endfunction

  task automatic run_stream(input int n, input bit rnd);
    logic [10:0] q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    dest_addr = 4'hA;
    while (got < n && cyc < 20000) begin
      tick();
      cyc++;
      in_valid   = (sent < n) && (!rnd || ($urandom_range(0, 1) == 1));
      in_data    = 11'($urandom);
      flit_ready = !rnd || ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      if (flit_valid && flit_ready) begin
        if (flit_tail) begin
          if (q.size() == 0) begin
            check("stream_tail_extra", 32'd1, 32'd0);
          end else begin
            check("stream_tail", {16'd0, flit_out}, {16'd0, tail_exp(q.pop_front())});
          end
          got++;
          exp_seq = exp_seq + 6'd1;
        end else begin
          check("stream_head", {16'd0, flit_out}, {16'd0, head_exp(4'hA)});
        end
      end
    end
    check("stream_count", got, n);
    in_valid = 1'b0;
    tick();
    flit_ready = 1'b1;
    tick();
    check("stream_left", q.size(), 0);
    check("stream_idle", {31'd0, flit_valid}, 32'd0);
  endtask

  initial begin
    words[0] = 11'h001;
    words[1] = 11'h3FF;
    words[2] = 11'h2A5;
    words[3] = 11'h0C3;
    RESET = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    dest_addr = 4'h0;
    flit_ready = 1'b0;

    // 1: reset values, then a single packet
    tick();
    tick();
    check("rst_valid", {31'd0, flit_valid}, 32'd0);
    check("rst_out", {16'd0, flit_out}, 32'd0);
    check("rst_tail", {31'd0, flit_tail}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    RESET = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);
    in_data = 11'h155;
    in_valid = 1'b1;
    dest_addr = 4'h3;
    flit_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_no_early_head", {31'd0, flit_valid}, 32'd0);
    tick();
    check("t1_head", {16'd0, flit_out}, 32'h4C80);
    check("t1_head_valid", {31'd0, flit_valid}, 32'd1);
    check("t1_head_tail", {31'd0, flit_tail}, 32'd0);
    tick();
    check("t1_tail", {16'd0, flit_out}, 32'h8155);
    check("t1_tail_flag", {31'd0, flit_tail}, 32'd1);
    exp_seq = exp_seq + 6'd1;
    tick();
    check("t1_idle", {31'd0, flit_valid}, 32'd0);

    // 2: backpressure on head, dest change ignored
    flit_ready = 1'b0;
    in_data = 11'h2AA;
    in_valid = 1'b1;
    dest_addr = 4'h3;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_head", {16'd0, flit_out}, {16'd0, head_exp(4'h3)});
    for (int i = 0; i < 5; i++) begin
      dest_addr = 4'h7;
      tick();
      check("t2_hold", {16'd0, flit_out}, {16'd0, head_exp(4'h3)});
      check("t2_hold_valid", {31'd0, flit_valid}, 32'd1);
    end
    flit_ready = 1'b1;
    tick();
    check("t2_tail", {16'd0, flit_out}, 32'h82AA);
    exp_seq = exp_seq + 6'd1;
    tick();
    check("t2_idle", {31'd0, flit_valid}, 32'd0);

    // 3: fill FIFO under backpressure, reject fifth word, drain back-to-back
    flit_ready = 1'b0;
    dest_addr = 4'h5;
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_pre", {31'd0, in_ready}, 32'd1);
      in_data = words[i];
      in_valid = 1'b1;
      tick();
    end
    check("t3_full", {31'd0, in_ready}, 32'd0);
    in_data = 11'h7FF;
    tick();
    in_valid = 1'b0;
    check("t3_still_full", {31'd0, in_ready}, 32'd0);
    flit_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) tick();
      check("t3_head", {16'd0, flit_out}, {16'd0, head_exp(4'h5)});
      check("t3_head_valid", {31'd0, flit_valid}, 32'd1);
      tick();
      check("t3_tail", {16'd0, flit_out}, {16'd0, tail_exp(words[p])});
      check("t3_tail_flag", {31'd0, flit_tail}, 32'd1);
      exp_seq = exp_seq + 6'd1;
    end
    tick();
    check("t3_idle", {31'd0, flit_valid}, 32'd0);

    // 4: 65 packets, sequence field wraps
    run_stream(65, 1'b0);

    // 5: reset while tail held with two words queued
    flit_ready = 1'b0;
    dest_addr = 4'h3;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t5_head", {16'd0, flit_out}, {16'd0, head_exp(4'h3)});
    flit_ready = 1'b1;
    tick();
    flit_ready = 1'b0;
    check("t5_tail", {16'd0, flit_out}, {16'd0, tail_exp(words[0])});
    RESET = 1'b1;
    #1;
    check("t5_valid_drop", {31'd0, flit_valid}, 32'd0);
    check("t5_ready_low", {31'd0, in_ready}, 32'd0);
    exp_seq = '0;
    tick();
    RESET = 1'b0;
    #1;
    check("t5_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    check("t5_fifo_empty", {31'd0, flit_valid}, 32'd0);
    in_data = 11'h0AB;
    in_valid = 1'b1;
    flit_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_head_seq0", {16'd0, flit_out}, {16'd0, head_exp(4'h3)});
    tick();
    check("t5_tail_next", {16'd0, flit_out}, 32'h80AB);
    exp_seq = exp_seq + 6'd1;
    tick();

    // 6: random traffic, 1000 words
    run_stream(1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
